// File: rtl/cla16_rr_scheduler_if.sv
// Requester/response bus of the shared 16-bit adder scheduler.
// Master side: requesters plus the response consumer. Slave side: the scheduler.
interface cla16_rr_scheduler_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [16*NUM_REQ-1:0] req_a;
    logic [16*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    req_cin;
    logic [NUM_REQ-1:0]    req_chain;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [15:0]           rsp_sum;
    logic                  rsp_cout;
    logic                  rsp_last;

    modport master (
        output req_valid, req_a, req_b, req_cin, req_chain, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_last
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, req_chain, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_last
    );
endinterface

// File: rtl/cla16_rr_scheduler.sv
// Round-robin scheduler sharing one 16-bit carry-lookahead adder among
// NUM_REQ requesters, with multi-word chaining (carry passed word to word)
// and a single registered response entry tagged with the requester id.
// Optional build macro CLA16_SCHED_STATS_EN adds stat_words / stat_stall
// counters as extra output ports.

// Two-level carry-lookahead adder: 4-bit groups, group carries resolved
// directly from the global carry-in so no carry ripples between groups.
module carry_lookahead_adder_16bit (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_cin,
    output logic [15:0] o_sum,
    output logic        o_cout
);
    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [3:0]  w_gg;
    logic [3:0]  w_gp;
    logic [4:0]  w_gc;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_grp
            logic [3:0] w_gl;
            logic [3:0] w_pl;
            logic       w_c1;
            logic       w_c2;
            logic       w_c3;

            assign w_gl = w_g[4*gi +: 4];
            assign w_pl = w_p[4*gi +: 4];
            assign w_c1 = w_gl[0] | (w_pl[0] & w_gc[gi]);
            assign w_c2 = w_gl[1] | (w_pl[1] & w_gl[0]) | (w_pl[1] & w_pl[0] & w_gc[gi]);
            assign w_c3 = w_gl[2] | (w_pl[2] & w_gl[1]) | (w_pl[2] & w_pl[1] & w_gl[0])
                        | (w_pl[2] & w_pl[1] & w_pl[0] & w_gc[gi]);
            assign w_gg[gi] = w_gl[3] | (w_pl[3] & w_gl[2]) | (w_pl[3] & w_pl[2] & w_gl[1])
                            | (w_pl[3] & w_pl[2] & w_pl[1] & w_gl[0]);
            assign w_gp[gi] = &w_pl;
            assign o_sum[4*gi +: 4] = w_pl ^ {w_c3, w_c2, w_c1, w_gc[gi]};
        end
    endgenerate

    assign w_gc[0] = i_cin;
    assign w_gc[1] = w_gg[0] | (w_gp[0] & i_cin);
    assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & i_cin);
    assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[2] & w_gp[1] & w_gp[0] & i_cin);
    assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & i_cin);
    assign o_cout  = w_gc[4];
endmodule

module cla16_rr_scheduler #(
    parameter int NUM_REQ = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    cla16_rr_scheduler_if.slave    bus
`ifdef CLA16_SCHED_STATS_EN
    ,
    output logic [31:0]            stat_words,
    output logic [31:0]            stat_stall
`endif
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [IDW-1:0] r_owner;
    logic [IDW-1:0] w_owner_next;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] w_ptr_next;
    logic           r_carry;

    logic           r_rsp_valid;
    logic [IDW-1:0] r_rsp_id;
    logic [15:0]    r_rsp_sum;
    logic           r_rsp_cout;
    logic           r_rsp_last;

    logic [15:0]    w_a_arr [NUM_REQ];
    logic [15:0]    w_b_arr [NUM_REQ];

    logic           w_can_accept;
    logic           w_gnt_any;
    logic [IDW-1:0] w_gnt_id;
    logic           w_ready_en;
    logic           w_fire;
    logic           w_sel_cin;
    logic           w_chain;
    logic [15:0]    w_a;
    logic [15:0]    w_b;
    logic [15:0]    w_sum;
    logic           w_cout;

    // Unpack the flat operand buses into per-requester words.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_a_arr[gi] = bus.req_a[16*gi +: 16];
            assign w_b_arr[gi] = bus.req_b[16*gi +: 16];
        end
    endgenerate

    // Grant selection: locked owner only, else first valid from the pointer.
    // The loop runs from the farthest offset down so the nearest one wins.
    always_comb begin
        logic [IDW:0] v_pos;
        v_pos     = '0;
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        if (r_state == S_LOCKED) begin
            w_gnt_id  = r_owner;
            w_gnt_any = bus.req_valid[r_owner];
        end else begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                v_pos = {1'b0, r_ptr} + (IDW+1)'(i);
                if (v_pos >= (IDW+1)'(NUM_REQ)) begin
                    v_pos = v_pos - (IDW+1)'(NUM_REQ);
                end
                if (bus.req_valid[v_pos[IDW-1:0]]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_id  = v_pos[IDW-1:0];
                end
            end
        end
    end

    assign w_can_accept = !r_rsp_valid || bus.rsp_ready;
    // A locked owner keeps its ready even while it pauses its valid.
    assign w_ready_en   = !rst && w_can_accept && ((r_state == S_LOCKED) || w_gnt_any);
    assign w_fire       = !rst && w_can_accept && w_gnt_any;
    assign bus.req_ready = w_ready_en ? (NUM_REQ'(1) << w_gnt_id) : '0;

    assign w_a       = w_a_arr[w_gnt_id];
    assign w_b       = w_b_arr[w_gnt_id];
    assign w_chain   = bus.req_chain[w_gnt_id];
    assign w_sel_cin = (r_state == S_LOCKED) ? r_carry : bus.req_cin[w_gnt_id];

    carry_lookahead_adder_16bit u_cla (
        .i_a    (w_a),
        .i_b    (w_b),
        .i_cin  (w_sel_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Next lock state, owner and pointer, updated only by a transfer.
    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        w_ptr_next   = r_ptr;
        if (w_fire) begin
            if (w_chain) begin
                w_state_next = S_LOCKED;
                w_owner_next = w_gnt_id;
            end else begin
                w_state_next = S_IDLE;
                w_ptr_next   = (w_gnt_id == IDW'(NUM_REQ - 1)) ? '0 : (w_gnt_id + IDW'(1));
            end
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_owner <= w_owner_next;
            r_ptr   <= w_ptr_next;
        end
    end

    // Single response entry plus the carry handed to the next chained word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_sum   <= '0;
            r_rsp_cout  <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_carry     <= 1'b0;
        end else if (w_fire) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= w_gnt_id;
            r_rsp_sum   <= w_sum;
            r_rsp_cout  <= w_cout;
            r_rsp_last  <= !w_chain;
            r_carry     <= w_cout;
        end else if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_sum   = r_rsp_sum;
    assign bus.rsp_cout  = r_rsp_cout;
    assign bus.rsp_last  = r_rsp_last;

`ifdef CLA16_SCHED_STATS_EN
    logic [31:0] r_stat_words;
    logic [31:0] r_stat_stall;

    // Transfer and stall counters; both wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_words <= '0;
            r_stat_stall <= '0;
        end else if (w_fire) begin
            r_stat_words <= r_stat_words + 32'd1;
        end else if (|bus.req_valid) begin
            r_stat_stall <= r_stat_stall + 32'd1;
        end
    end

    assign stat_words = r_stat_words;
    assign stat_stall = r_stat_stall;
`endif
endmodule
